// File: rtl/display_arbiter.sv
// Priority display arbiter with minimum hold time before preemption and optional blink gating.
// Define DISPLAY_ARBITER_BLINK_EN to include the blink counter and per-requester blink blanking.
module display_arbiter #(
   parameter int unsigned HOLD_TICKS  = 50000,
   parameter int unsigned BLINK_TICKS = 25000000
) (
   input  logic        clk,
   input  logic        Nreset,
   input  logic [2:0]  req,
   input  logic [31:0] data0,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   input  logic [2:0]  blink_en,
   output logic [2:0]  grant,
   output logic [31:0] to_display,
   output logic        blank,
   output logic        switch_pulse
);

   localparam int HW = $clog2(HOLD_TICKS + 1);
   typedef logic [HW-1:0] hold_t;
   localparam hold_t HOLD_LAST = hold_t'(HOLD_TICKS - 1);

   typedef enum logic [1:0] {IDLE, LOCKED, OPEN} state_t;

   state_t      state_q, state_d;
   logic [2:0]  grant_q, grant_d;
   hold_t       holdCnt_q, holdCnt_d;
   logic [31:0] toDisplay_q, toDisplay_d;
   logic        blank_q, blank_d;
   logic        switchPulse_q, switchPulse_d;
   logic [2:0]  highReq;
   logic        blinkBlank;

   always_comb begin
      highReq = 3'b000;
      if (req[2])      highReq = 3'b100;
      else if (req[1]) highReq = 3'b010;
      else if (req[0]) highReq = 3'b001;
   end

`ifdef DISPLAY_ARBITER_BLINK_EN
   localparam int BW = $clog2(BLINK_TICKS + 1);
   typedef logic [BW-1:0] blink_t;
   localparam blink_t BLINK_LAST = blink_t'(BLINK_TICKS - 1);

   blink_t blinkCnt_q;
   logic   phase_q;

   // Free-running half-period counter; phase 1 means the digits are visible.
   always_ff @(posedge clk or negedge Nreset) begin
      if (!Nreset) begin
         blinkCnt_q <= '0;
         phase_q    <= 1'b1;
      end else if (blinkCnt_q == BLINK_LAST) begin
         blinkCnt_q <= '0;
         phase_q    <= ~phase_q;
      end else begin
         blinkCnt_q <= blinkCnt_q + 1'b1;
      end
   end

   assign blinkBlank = (|(blink_en & grant_q)) & ~phase_q;
`else
   localparam int unsigned unusedBlinkTicks = BLINK_TICKS;
   logic unusedBlinkEn;
   assign unusedBlinkEn = ^blink_en;
   assign blinkBlank    = 1'b0;
`endif

   // Owner release or an allowed preemption both pick the highest live request in one step.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      holdCnt_d = holdCnt_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d   = highReq;
               holdCnt_d = '0;
               state_d   = LOCKED;
            end
         end
         default: begin
            if (((req & grant_q) == 3'b000) || ((state_q == OPEN) && (highReq > grant_q))) begin
               grant_d   = highReq;
               holdCnt_d = '0;
               state_d   = (|req) ? LOCKED : IDLE;
            end else if (state_q == LOCKED) begin
               if (holdCnt_q == HOLD_LAST) state_d = OPEN;
               else                        holdCnt_d = holdCnt_q + 1'b1;
            end
         end
      endcase
   end

   // Display data lags the grant by one cycle but blanks immediately on entering idle.
   always_comb begin
      switchPulse_d = (grant_d != grant_q);
      toDisplay_d   = 32'hFFFF_FFFF;
      blank_d       = 1'b1;
      if ((grant_q != 3'b000) && (grant_d != 3'b000)) begin
         blank_d = blinkBlank;
         case (grant_q)
            3'b001:  toDisplay_d = data0;
            3'b010:  toDisplay_d = data1;
            3'b100:  toDisplay_d = data2;
            default: toDisplay_d = 32'hFFFF_FFFF;
         endcase
      end
   end

   always_ff @(posedge clk or negedge Nreset) begin
      if (!Nreset) begin
         state_q       <= IDLE;
         grant_q       <= 3'b000;
         holdCnt_q     <= '0;
         toDisplay_q   <= 32'hFFFF_FFFF;
         blank_q       <= 1'b1;
         switchPulse_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         holdCnt_q     <= holdCnt_d;
         toDisplay_q   <= toDisplay_d;
         blank_q       <= blank_d;
         switchPulse_q <= switchPulse_d;
      end
   end

   assign grant        = grant_q;
   assign to_display   = toDisplay_q;
   assign blank        = blank_q;
   assign switch_pulse = switchPulse_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: directed scenarios plus randomized traffic
// compared every cycle against an owner/age model of the arbitration rules.
module tb_display_arbiter;

   localparam int HOLD = 4;
   localparam int BT   = 3;

   logic        clk = 1'b0;
   logic        Nreset = 1'b0;
   logic [2:0]  req = 3'b000;
   logic [2:0]  blink_en = 3'b000;
   logic [31:0] data0 = '0, data1 = '0, data2 = '0;
   logic [2:0]  grant;
   logic [31:0] to_display;
   logic        blank;
   logic        switch_pulse;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   display_arbiter #(.HOLD_TICKS(HOLD), .BLINK_TICKS(BT)) dut (
      .clk(clk), .Nreset(Nreset), .req(req),
      .data0(data0), .data1(data1), .data2(data2),
      .blink_en(blink_en), .grant(grant), .to_display(to_display),
      .blank(blank), .switch_pulse(switch_pulse)
   );

   // Model: owner index (-1 idle), edges since the owner was granted, edges since reset.
   int          mOwner = -1;
   int          mAge = 0;
   int          mEdges = 0;
   logic [2:0]  eGrant = 3'b000;
   logic [31:0] eDisp = 32'hFFFF_FFFF;
   logic        eBlank = 1'b1;
   logic        ePulse = 1'b0;

   function automatic int topBit(input logic [2:0] r);
      for (int i = 2; i >= 0; i--) if (r[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] dataOf(input int idx);
      if (idx == 0) return data0;
      if (idx == 1) return data1;
      return data2;
   endfunction

   always @(posedge clk or negedge Nreset) begin
      if (!Nreset) begin
         mOwner = -1; mAge = 0; mEdges = 0;
         eGrant = 3'b000; eDisp = 32'hFFFF_FFFF; eBlank = 1'b1; ePulse = 1'b0;
      end else begin
         int   hi, prev, nxt;
         logic visible;
         hi   = topBit(req);
         prev = mOwner;
         if (prev < 0)                        nxt = hi;
         else if (!req[prev])                 nxt = hi;
         else if (mAge >= HOLD && hi > prev)  nxt = hi;
         else                                 nxt = prev;
         ePulse = (nxt != prev);
         eGrant = (nxt < 0) ? 3'b000 : 3'(1 << nxt);
         visible = (((mEdges / BT) % 2) == 0);
         if (prev < 0 || nxt < 0) begin
            eDisp  = 32'hFFFF_FFFF;
            eBlank = 1'b1;
         end else begin
            eDisp = dataOf(prev);
`ifdef DISPLAY_ARBITER_BLINK_EN
            eBlank = blink_en[prev] && !visible;
`else
            eBlank = 1'b0;
`endif
         end
         if (nxt != prev) mAge = 0;
         else if (mAge < 1000) mAge++;
         mOwner = nxt;
         mEdges++;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   // Literal expectations pin both the DUT and the model.
   task automatic checkLit(input string name, input logic [31:0] actual, input logic [31:0] model,
                           input logic [31:0] lit);
      checkOutput(name, actual, lit);
      checkOutput({name, "_model"}, model, lit);
   endtask

   always @(negedge clk) begin
      checkOutput("grant", {29'd0, grant}, {29'd0, eGrant});
      checkOutput("to_display", to_display, eDisp);
      checkOutput("blank", {31'd0, blank}, {31'd0, eBlank});
      checkOutput("switch_pulse", {31'd0, switch_pulse}, {31'd0, ePulse});
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic [2:0] r, input logic [2:0] be);
      req      = r;
      blink_en = be;
   endtask

   logic blankHist [0:8];

   initial begin
      data0 = 32'h0012_3456;
      data1 = 32'hAAAA_1111;
      data2 = 32'h2222_BBBB;
      tick(); tick();
      checkLit("rst_grant", {29'd0, grant}, {29'd0, eGrant}, 32'd0);
      checkLit("rst_disp", to_display, eDisp, 32'hFFFF_FFFF);
      checkLit("rst_blank", {31'd0, blank}, {31'd0, eBlank}, 32'd1);
      checkLit("rst_pulse", {31'd0, switch_pulse}, {31'd0, ePulse}, 32'd0);

      Nreset = 1'b1;
      applyStimulus(3'b001, 3'b000);
      tick();
      checkLit("first_grant", {29'd0, grant}, {29'd0, eGrant}, 32'd1);
      checkLit("first_pulse", {31'd0, switch_pulse}, {31'd0, ePulse}, 32'd1);
      checkLit("first_disp_lag", to_display, eDisp, 32'hFFFF_FFFF);
      applyStimulus(3'b011, 3'b000);
      tick();
      checkLit("first_disp", to_display, eDisp, 32'h0012_3456);
      checkLit("first_blank", {31'd0, blank}, {31'd0, eBlank}, 32'd0);
      checkLit("locked_pulse", {31'd0, switch_pulse}, {31'd0, ePulse}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkLit("locked_hold", {29'd0, grant}, {29'd0, eGrant}, 32'd1);
      end
      tick();
      checkLit("open_preempt", {29'd0, grant}, {29'd0, eGrant}, 32'd2);
      checkLit("open_pulse", {31'd0, switch_pulse}, {31'd0, ePulse}, 32'd1);
      applyStimulus(3'b010, 3'b000);
      tick();
      checkLit("disp_data1", to_display, eDisp, 32'hAAAA_1111);
      repeat (3) tick();
      applyStimulus(3'b100, 3'b000);
      tick();
      checkLit("swap_grant", {29'd0, grant}, {29'd0, eGrant}, 32'd4);
      checkLit("swap_pulse", {31'd0, switch_pulse}, {31'd0, ePulse}, 32'd1);
      tick();
      checkLit("swap_disp", to_display, eDisp, 32'h2222_BBBB);
      checkLit("swap_single", {31'd0, switch_pulse}, {31'd0, ePulse}, 32'd0);
      applyStimulus(3'b000, 3'b000);
      tick();
      checkLit("idle_grant", {29'd0, grant}, {29'd0, eGrant}, 32'd0);
      checkLit("idle_blank", {31'd0, blank}, {31'd0, eBlank}, 32'd1);
      checkLit("idle_disp", to_display, eDisp, 32'hFFFF_FFFF);
      checkLit("idle_pulse", {31'd0, switch_pulse}, {31'd0, ePulse}, 32'd1);
      tick();

      applyStimulus(3'b010, 3'b010);
      tick(); tick();
      for (int k = 0; k < 9; k++) begin
         tick();
         blankHist[k] = blank;
`ifdef DISPLAY_ARBITER_BLINK_EN
         if (k >= 3) checkOutput("blink_period", {31'd0, blank}, {31'd0, ~blankHist[k-3]});
`else
         checkOutput("blink_off", {31'd0, blank}, 32'd0);
`endif
      end

      applyStimulus(3'b000, 3'b000);
      tick();
      applyStimulus(3'b001, 3'b000);
      tick(); tick();
      #1 Nreset = 1'b0;
      #1;
      checkLit("async_grant", {29'd0, grant}, {29'd0, eGrant}, 32'd0);
      checkLit("async_disp", to_display, eDisp, 32'hFFFF_FFFF);
      checkLit("async_blank", {31'd0, blank}, {31'd0, eBlank}, 32'd1);
      checkLit("async_pulse", {31'd0, switch_pulse}, {31'd0, ePulse}, 32'd0);
      tick();
      Nreset = 1'b1;
      applyStimulus(3'b100, 3'b000);
      tick();
      checkLit("post_rst_grant", {29'd0, grant}, {29'd0, eGrant}, 32'd4);
      checkLit("post_rst_pulse", {31'd0, switch_pulse}, {31'd0, ePulse}, 32'd1);

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
         data0 = $urandom;
         data1 = $urandom;
         data2 = $urandom;
         if ($urandom_range(0, 15) == 0) blink_en = 3'($urandom_range(0, 7));
         Nreset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
